shift_sequencer: RTL

Serial transfer controller for the `WIDTH`-bit universal shift register datapath. It accepts a parallel word over a valid/ready handshake and loads it into the register. It then issues exactly `WIDTH` shift commands paced by an external bit strobe, driving the serial output and capturing the serial input into the same register. The received word is presented over a second valid/ready handshake. It sits between the link framing logic and the shift register and owns the register's `mode`/`din`/`si` inputs.

---
 rtl/shift_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Purpose : serial transfer controller driving a WIDTH-bit universal shift register.
// Latency : word accepted in cycle A, shifting from A+1, m_valid the cycle after the WIDTH-th bit_en.
// Backpressure: s_ready only in IDLE (or DONE with m_ready when back-to-back is enabled); DONE holds until m_ready.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset (all outputs forced low while rst=1)
//   s_valid/s_ready   - transmit word handshake; s_data word, s_lsb_first bit order sampled at accept
//   bit_en            - one-cycle bit strobe, one shift per strobe while shifting
//   sdo, sdo_active   - serial output and its activity flag
//   sdi               - serial input, captured into the register on strobe cycles
//   m_valid/m_ready   - received word handshake; m_data received word
//   sr_mode, sr_din, sr_si - datapath controls (00 hold, 01 shl, 10 shr, 11 load)
//   sr_q, sr_so_left, sr_so_right - datapath contents and its two serial outputs
//
// Build option: define SHIFT_SEQ_B2B_EN to allow loading the next word in the same
// cycle the received word is handed off (word period WIDTH+1 instead of WIDTH+2).

module shift_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_lsb_first,
    input  logic             bit_en,
    output logic             sdo,
    output logic             sdo_active,
    input  logic             sdi,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_din,
    output logic             sr_si,
    input  logic [WIDTH-1:0] sr_q,
    input  logic             sr_so_left,
    input  logic             sr_so_right
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lsb, lsb_nxt;

    // State register. The datapath itself is not reset: while rst is high
    // sr_mode is forced to hold, so its contents are simply left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lsb   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lsb   <= lsb_nxt;
        end
    end

    // Next-state and output decode. s_ready and m_valid depend on state
    // (and m_ready for the hand-off case) only, never on s_valid.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        lsb_nxt    = lsb;
        s_ready    = 1'b0;
        sdo        = 1'b0;
        sdo_active = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        sr_mode    = MODE_HOLD;
        sr_din     = '0;
        sr_si      = 1'b0;

        case (state)
            IDLE: begin
                s_ready = 1'b1;
                sr_din  = s_data;
                if (s_valid) begin
                    // Register loads on the same edge the word is accepted.
                    sr_mode   = MODE_LOAD;
                    lsb_nxt   = s_lsb_first;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                sdo_active = 1'b1;
                // LSB-first shifts right, so the outgoing bit is q[0];
                // MSB-first shifts left and sends q[WIDTH-1].
                sdo   = lsb ? sr_so_right : sr_so_left;
                sr_si = sdi;
                if (bit_en) begin
                    sr_mode = lsb ? MODE_SHR : MODE_SHL;
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            DONE: begin
                m_valid = 1'b1;
                m_data  = sr_q;
`ifdef SHIFT_SEQ_B2B_EN
                s_ready = m_ready;
                if (m_ready) begin
                    if (s_valid) begin
                        // Hand off the received word and load the next one
                        // on the same edge; the register is free after it.
                        sr_mode   = MODE_LOAD;
                        sr_din    = s_data;
                        lsb_nxt   = s_lsb_first;
                        cnt_nxt   = '0;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`else
                if (m_ready) begin
                    state_nxt = IDLE;
                end
`endif
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                lsb_nxt   = 1'b0;
            end
        endcase

        // Reset silences every output, including the handshakes and the
        // datapath mode, regardless of the decoded state.
        if (rst) begin
            s_ready    = 1'b0;
            sdo        = 1'b0;
            sdo_active = 1'b0;
            m_valid    = 1'b0;
            m_data     = '0;
            sr_mode    = MODE_HOLD;
            sr_din     = '0;
            sr_si      = 1'b0;
        end
    end

endmodule
